// File: rtl/serial_ripple_sub.sv
// Bit-serial ripple-borrow subtractor: recovers one addend from an adder sum and the other addend.
// One difference bit per clock, LSB first, with valid/ready handshakes on both sides.
module serial_ripple_sub #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH:0]   i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_borrow,
    output logic             o_range_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           borrow;
    logic [WIDTH:0] minuend_q;
    logic [WIDTH:0] subtrahend_q;

    logic bit_a;
    logic bit_b;
    logic diff_bit;
    logic borrow_next;

    assign o_ready = (state == IDLE) & ~i_rst;

    // Full-subtractor cell for the bit currently selected by cnt
    always_comb begin
        bit_a       = minuend_q[cnt];
        bit_b       = subtrahend_q[cnt];
        diff_bit    = bit_a ^ bit_b ^ borrow;
        borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            borrow       <= 1'b0;
            minuend_q    <= '0;
            subtrahend_q <= '0;
            o_valid      <= 1'b0;
            o_result     <= '0;
            o_borrow     <= 1'b0;
            o_range_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        minuend_q    <= i_minuend;
                        subtrahend_q <= {1'b0, i_subtrahend};
                        borrow       <= 1'b0;
                        o_result     <= '0;
                        cnt          <= '0;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    o_result[cnt] <= diff_bit;
                    borrow        <= borrow_next;
                    cnt           <= cnt + 1'b1;
                    // The top bit doubles as the overflow indicator for a WIDTH-bit result
                    if (cnt == LAST_BIT) begin
                        o_borrow    <= borrow_next;
                        o_range_err <= borrow_next | diff_bit;
                        o_valid     <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_sub.sv
// Self-checking bench for serial_ripple_sub: directed cases, full round-trip sweep,
// and randomized handshake/reset traffic compared every cycle against a transaction model.
module tb_serial_ripple_sub;

    localparam int WIDTH = 4;
    localparam int MW    = WIDTH + 1;
    localparam int MOD   = 1 << MW;

    logic             i_clk;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH:0]   i_minuend;
    logic [WIDTH-1:0] i_subtrahend;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;
    logic             o_borrow;
    logic             o_range_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model state
    int             m_wait     = 0;
    logic           exp_valid  = 1'b0;
    logic           exp_clear  = 1'b1;
    logic [WIDTH:0] exp_res    = '0;
    logic           exp_bor    = 1'b0;
    logic           exp_rng    = 1'b0;
    logic [WIDTH:0] pend_res   = '0;
    logic           pend_bor   = 1'b0;
    logic           pend_rng   = 1'b0;
    logic           check_en   = 1'b0;

    serial_ripple_sub #(.WIDTH(WIDTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_minuend    (i_minuend),
        .i_subtrahend (i_subtrahend),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_borrow     (o_borrow),
        .o_range_err  (o_range_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Each operation: accept, then the difference appears WIDTH+1 edges later and holds until consumed
    always @(posedge i_clk) begin
        if (i_rst) begin
            m_wait    = 0;
            exp_valid = 1'b0;
            exp_clear = 1'b1;
            exp_res   = '0;
            exp_bor   = 1'b0;
            exp_rng   = 1'b0;
        end else if (exp_valid) begin
            if (i_ready) exp_valid = 1'b0;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                exp_valid = 1'b1;
                exp_res   = pend_res;
                exp_bor   = pend_bor;
                exp_rng   = pend_rng;
            end
        end else if (i_valid) begin
            int m, s, d;
            m = int'(i_minuend);
            s = int'(i_subtrahend);
            d = (m - s + MOD) % MOD;
            pend_res  = MW'(d);
            pend_bor  = (m < s);
            pend_rng  = (m < s) || (d >= (1 << WIDTH));
            m_wait    = WIDTH + 1;
            exp_clear = 1'b0;
        end
    end

    always @(negedge i_clk) begin
        if (check_en) begin
            checkOutput("cyc_o_valid", 32'(o_valid), 32'(exp_valid));
            checkOutput("cyc_o_ready", 32'(o_ready), 32'(!exp_valid && m_wait == 0 && !i_rst));
            if (exp_valid || exp_clear) begin
                checkOutput("cyc_o_result", 32'(o_result), 32'(exp_res));
                checkOutput("cyc_o_borrow", 32'(o_borrow), 32'(exp_bor));
                checkOutput("cyc_o_range_err", 32'(o_range_err), 32'(exp_rng));
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH:0] m, input logic [WIDTH-1:0] s);
        int lat;
        i_minuend    = m;
        i_subtrahend = s;
        i_valid      = 1'b1;
        lat = 0;
        while (!o_ready && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 4 * WIDTH + 10) begin
            @(posedge i_clk); #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(WIDTH + 1));
    endtask

    task automatic consumeResult();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checkOutput("ready_after_consume", 32'(o_ready), 32'd1);
        checkOutput("valid_after_consume", 32'(o_valid), 32'd0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_minuend    = '0;
        i_subtrahend = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_o_result", 32'(o_result), 32'd0);
        checkOutput("reset_o_ready_in_reset", 32'(o_ready), 32'd0);
        i_rst    = 1'b0;
        check_en = 1'b1;
        #1;
        checkOutput("reset_o_ready_after", 32'(o_ready), 32'd1);

        $display("[TB] directed: 19-7, 0-1, 30-9");
        applyStimulus(5'd19, 4'd7);
        checkOutput("t1_result", 32'(o_result), 32'd12);
        checkOutput("t1_borrow", 32'(o_borrow), 32'd0);
        checkOutput("t1_range", 32'(o_range_err), 32'd0);
        consumeResult();

        applyStimulus(5'd0, 4'd1);
        checkOutput("t2_result", 32'(o_result), 32'h1f);
        checkOutput("t2_borrow", 32'(o_borrow), 32'd1);
        checkOutput("t2_range", 32'(o_range_err), 32'd1);
        consumeResult();

        applyStimulus(5'd30, 4'd9);
        checkOutput("t3_result", 32'(o_result), 32'd21);
        checkOutput("t3_borrow", 32'(o_borrow), 32'd0);
        checkOutput("t3_range", 32'(o_range_err), 32'd1);

        $display("[TB] back-pressure hold");
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            checkOutput("bp_valid", 32'(o_valid), 32'd1);
            checkOutput("bp_result", 32'(o_result), 32'd21);
            checkOutput("bp_range", 32'(o_range_err), 32'd1);
            checkOutput("bp_ready", 32'(o_ready), 32'd0);
        end
        consumeResult();

        $display("[TB] reset during shift");
        i_minuend    = 5'd27;
        i_subtrahend = 4'd14;
        i_valid      = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checkOutput("rst_shift_ready_in_reset", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        #1;
        checkOutput("rst_shift_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_shift_result", 32'(o_result), 32'd0);
        checkOutput("rst_shift_borrow", 32'(o_borrow), 32'd0);
        checkOutput("rst_shift_range", 32'(o_range_err), 32'd0);
        checkOutput("rst_shift_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk); #1;
            checkOutput("rst_shift_no_valid", 32'(o_valid), 32'd0);
        end
        applyStimulus(5'd15, 4'd3);
        checkOutput("t5_result", 32'(o_result), 32'd12);
        consumeResult();

        $display("[TB] adder round-trip sweep");
        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 0; b < (1 << WIDTH); b++) begin
                applyStimulus(MW'(a + b), WIDTH'(b));
                checkOutput("rt_result", 32'(o_result), 32'(a));
                checkOutput("rt_borrow", 32'(o_borrow), 32'd0);
                checkOutput("rt_range", 32'(o_range_err), 32'd0);
                consumeResult();
            end
        end

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            @(posedge i_clk); #1;
            i_valid      = ($urandom_range(0, 1) == 1);
            i_ready      = ($urandom_range(0, 3) != 0);
            i_rst        = ($urandom_range(0, 199) == 0);
            i_minuend    = MW'($urandom);
            i_subtrahend = WIDTH'($urandom);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_rst   = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
